fnd_reader: RTL and testbench

- Reads back a time-multiplexed 7-segment (FND) display bus and recovers the BCD digit on each position.
- It is the inverse of the team's BCD-to-FND segment decoder.
- It snoops active-low segment lines plus one-hot digit selects, waits for each pattern to settle, and decodes it back to 4 bits.
- A complete multi-digit frame is presented on a valid/ready output. Used for self-check of the display path and for board-level loopback.

---
 rtl/fnd_reader_if.sv | 25 ++
 rtl/fnd_reader.sv | 152 +++++++++++++++
 tb/tb_fnd_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_reader_if.sv
// Bus between an FND display source and the fnd_reader.
// The master drives the snooped segment/select lines and the ready
// handshake; the slave (the reader) returns the decoded frame.
interface fnd_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              i_FND;
  logic [NUM_DIGITS-1:0]   i_Digit_Sel;
  logic                    i_Ready;
  logic [4*NUM_DIGITS-1:0] o_Data;
  logic [NUM_DIGITS-1:0]   o_Blank;
  logic                    o_Valid;
  logic                    o_Err;
  logic                    o_Drop;

  modport master (
    output i_FND, i_Digit_Sel, i_Ready,
    input  o_Data, o_Blank, o_Valid, o_Err, o_Drop
  );

  modport slave (
    input  i_FND, i_Digit_Sel, i_Ready,
    output o_Data, o_Blank, o_Valid, o_Err, o_Drop
  );
endinterface

// File: rtl/fnd_reader.sv
// fnd_reader: recovers BCD digits from a multiplexed active-low 7-segment
// bus. Each one-hot digit select plus segment pattern must stay unchanged
// for STABLE_CYCLES registered compares before the position is captured;
// a full set of positions is offered as one frame on a valid/ready port.
// Build option: define FND_READER_ERR_EN to capture undecodable patterns
// as 4'hE and report them on o_Err; otherwise such dwells are ignored.
module fnd_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic         i_Clk,
  input logic         i_Rst,
  fnd_reader_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Returns {blank, err, value} for one segment pattern.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 6'h00;
      7'b1111001: decode = 6'h01;
      7'b0100100: decode = 6'h02;
      7'b0110000: decode = 6'h03;
      7'b0011001: decode = 6'h04;
      7'b0010010: decode = 6'h05;
      7'b0000010: decode = 6'h06;
      7'b1011000: decode = 6'h07;
      7'b0000000: decode = 6'h08;
      7'b0011000: decode = 6'h09;
      7'b1111111: decode = 6'h2F;
      default:    decode = 6'h1E;
    endcase
  endfunction

  logic [6:0]              fnd_p0, fnd_p1;
  logic [NUM_DIGITS-1:0]   sel_p0, sel_p1;
  logic [CNT_W-1:0]        cnt_p1, cnt_nxt;
  logic [5:0]              dec_p0;
  logic                    onehot_p0, same_p0, take_p0, cap_vld_p1;
  logic [4*NUM_DIGITS-1:0] shd_data;
  logic [NUM_DIGITS-1:0]   shd_blank, mask;
  logic                    complete, load, drop_nxt;
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    valid_q, drop_q;
`ifdef FND_READER_ERR_EN
  logic [NUM_DIGITS-1:0]   shd_err;
  logic                    err_q;
`endif

  // Stage p0/p1: current registered sample and the one before it.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      fnd_p0 <= '0;
      sel_p0 <= '0;
      fnd_p1 <= '0;
      sel_p1 <= '0;
    end else begin
      fnd_p0 <= bus.i_FND;
      sel_p0 <= bus.i_Digit_Sel;
      fnd_p1 <= fnd_p0;
      sel_p1 <= sel_p0;
    end
  end

  // Stability qualification and saturating dwell counter update.
  always_comb begin
    dec_p0    = decode(fnd_p0);
    onehot_p0 = (sel_p0 != '0) && ((sel_p0 & (sel_p0 - NUM_DIGITS'(1))) == '0);
    same_p0   = (fnd_p0 == fnd_p1) && (sel_p0 == sel_p1);
`ifdef FND_READER_ERR_EN
    take_p0   = 1'b1;
`else
    take_p0   = !dec_p0[4];
`endif
    cnt_nxt = '0;
    if (onehot_p0 && same_p0 && take_p0) begin
      cnt_nxt = (cnt_p1 == CNT_MAX) ? cnt_p1 : cnt_p1 + CNT_W'(1);
    end
    cap_vld_p1 = (cnt_nxt == CNT_MAX) && (cnt_p1 != CNT_MAX);
  end

  // Frame completion and output-register acceptance decisions.
  always_comb begin
    complete = &mask;
    load     = complete && (!valid_q || bus.i_Ready);
    drop_nxt = complete && valid_q && !bus.i_Ready;
  end

  // Stage p1: dwell counter, shadow slots and captured mask.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_p1    <= '0;
      shd_data  <= '0;
      shd_blank <= '0;
      mask      <= '0;
`ifdef FND_READER_ERR_EN
      shd_err   <= '0;
`endif
    end else begin
      cnt_p1 <= cnt_nxt;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_vld_p1 && sel_p0[k]) begin
          shd_data[4*k +: 4] <= dec_p0[3:0];
          shd_blank[k]       <= dec_p0[5];
`ifdef FND_READER_ERR_EN
          shd_err[k]         <= dec_p0[4];
`endif
        end
      end
      mask <= (complete ? '0 : mask) | (cap_vld_p1 ? sel_p0 : '0);
    end
  end

  // Stage p2: held output frame with valid/ready handshake and drop pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      data_q  <= '0;
      blank_q <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
`ifdef FND_READER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      drop_q <= drop_nxt;
      if (load) begin
        data_q  <= shd_data;
        blank_q <= shd_blank;
        valid_q <= 1'b1;
`ifdef FND_READER_ERR_EN
        err_q   <= |shd_err;
`endif
      end else if (valid_q && bus.i_Ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_Data  = data_q;
  assign bus.o_Blank = blank_q;
  assign bus.o_Valid = valid_q;
  assign bus.o_Drop  = drop_q;
`ifdef FND_READER_ERR_EN
  assign bus.o_Err   = err_q;
`else
  assign bus.o_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_fnd_reader.sv
// Testbench for fnd_reader: directed display scans with a frame-level
// reference model compared every cycle, plus literal frame expectations.
module tb_fnd_reader;
  localparam int ND = 4;
  localparam int SC = 4;
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h58, 7'h00, 7'h18};
`ifdef FND_READER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  fnd_reader_if #(.NUM_DIGITS(ND)) bus();

  fnd_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_decode(input logic [6:0] f, output logic [3:0] v,
                                   output bit b, output bit e);
    v = 4'hE; b = 1'b0; e = 1'b1;
    if (f == 7'h7f) begin
      v = 4'hF; b = 1'b1; e = 1'b0;
    end else begin
      for (int i = 0; i < 10; i++)
        if (f == SEG[i]) begin v = 4'(i); e = 1'b0; end
    end
  endfunction

  // Reference model state (frame level)
  logic [6:0]  m_prev_f = '0;
  logic [3:0]  m_prev_s = '0;
  int          m_run = 0;
  bit          m_pcap = 0, m_pcomp = 0;
  int          m_ppos = 0;
  logic [6:0]  m_pf = '0;
  logic [15:0] m_sh_d = '0;
  logic [3:0]  m_sh_b = '0, m_sh_e = '0, m_mask = '0;
  logic [15:0] m_data = '0, m_acc_d = '0;
  logic [3:0]  m_blank = '0;
  bit          m_valid = 0, m_err = 0, m_drop = 0;

  // DUT observation
  bit          prev_v = 0;
  int          dut_vrise = 0, dut_vhigh = 0, dut_drops = 0;
  logic [15:0] last_d = '0;
  logic [3:0]  last_b = '0;
  bit          last_e = 0;

  always begin
    logic [6:0] cf;
    logic [3:0] cs, v;
    bit b, e;
    @(posedge clk);
    if (rst) begin
      m_prev_f = '0; m_prev_s = '0; m_run = 0; m_pcap = 0; m_pcomp = 0;
      m_sh_d = '0; m_sh_b = '0; m_sh_e = '0; m_mask = '0;
      m_data = '0; m_blank = '0; m_valid = 0; m_err = 0; m_drop = 0;
    end else begin
      m_drop = 0;
      if (m_valid && bus.i_Ready) m_acc_d = m_data;
      if (m_pcomp) begin
        m_pcomp = 0;
        if (!m_valid || bus.i_Ready) begin
          m_data = m_sh_d; m_blank = m_sh_b; m_err = |m_sh_e; m_valid = 1;
        end else begin
          m_drop = 1;
        end
      end else if (m_valid && bus.i_Ready) begin
        m_valid = 0;
      end
      if (m_pcap) begin
        m_pcap = 0;
        m_decode(m_pf, v, b, e);
        m_sh_d[4*m_ppos +: 4] = v;
        m_sh_b[m_ppos] = b;
        m_sh_e[m_ppos] = e;
        m_mask[m_ppos] = 1'b1;
        if (m_mask == 4'hF) begin m_pcomp = 1; m_mask = '0; end
      end
      cf = bus.i_FND;
      cs = bus.i_Digit_Sel;
      if (cf == m_prev_f && cs == m_prev_s) m_run++;
      else m_run = 1;
      m_prev_f = cf;
      m_prev_s = cs;
      m_decode(cf, v, b, e);
      if ($countones(cs) == 1 && (ERR_EN || !e) && m_run == SC + 1) begin
        m_pcap = 1;
        m_pf = cf;
        for (int k = 0; k < ND; k++) if (cs[k]) m_ppos = k;
      end
    end
    #1;
    chk("valid", bus.o_Valid, m_valid);
    chk("drop", bus.o_Drop, m_drop);
    if (m_valid) begin
      chk("data", bus.o_Data, m_data);
      chk("blank", bus.o_Blank, m_blank);
      chk("err", bus.o_Err, m_err);
    end
    if (bus.o_Valid && !prev_v) dut_vrise++;
    if (bus.o_Valid) begin
      dut_vhigh++;
      last_d = bus.o_Data; last_b = bus.o_Blank; last_e = bus.o_Err;
    end
    if (bus.o_Drop) dut_drops++;
    prev_v = bus.o_Valid;
  end

  task automatic dwell(input int pos, input logic [6:0] f, input int n);
    @(negedge clk);
    bus.i_FND = f;
    bus.i_Digit_Sel = 4'(1 << pos);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.i_FND = 7'h7f;
    bus.i_Digit_Sel = '0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_FND = 7'h7f;
    bus.i_Digit_Sel = '0;
    #1;
    chk("rst_valid", bus.o_Valid, 0);
    chk("rst_data", bus.o_Data, 0);
    chk("rst_blank", bus.o_Blank, 0);
    chk("rst_err", bus.o_Err, 0);
    chk("rst_drop", bus.o_Drop, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int v0, h0, d0;
    bus.i_FND = 7'h7f;
    bus.i_Digit_Sel = '0;
    bus.i_Ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_valid", bus.o_Valid, 0);
    chk("init_data", bus.o_Data, 0);
    chk("init_blank", bus.o_Blank, 0);
    chk("init_drop", bus.o_Drop, 0);
    rst = 1'b0;

    // 1: basic scan, ready high
    v0 = dut_vrise; h0 = dut_vhigh;
    dwell(0, 7'h79, 8); dwell(1, 7'h24, 8); dwell(2, 7'h30, 8); dwell(3, 7'h19, 8);
    idle(4);
    chk("t1_frames", dut_vrise - v0, 1);
    chk("t1_valid_cycles", dut_vhigh - h0, 1);
    chk("t1_data", last_d, 16'h4321);
    chk("t1_blank", last_b, 4'b0000);
    chk("t1_err", last_e, 0);
    chk("t1_valid_low", bus.o_Valid, 0);

    // 2: blank position
    v0 = dut_vrise;
    dwell(0, 7'h58, 8); dwell(1, 7'h58, 8); dwell(2, 7'h7f, 8); dwell(3, 7'h58, 8);
    idle(4);
    chk("t2_frames", dut_vrise - v0, 1);
    chk("t2_data", last_d, 16'h7F77);
    chk("t2_blank", last_b, 4'b0100);

    // 3: short dwells and multi-hot select never capture
    v0 = dut_vrise;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < ND; p++) dwell(p, SEG[p + 1], 3);
    @(negedge clk);
    bus.i_FND = 7'h79;
    bus.i_Digit_Sel = 4'b0011;
    repeat (7) @(negedge clk);
    idle(4);
    chk("t3_frames", dut_vrise - v0, 0);
    chk("t3_valid", bus.o_Valid, 0);

    // 4: backpressure, second frame dropped
    v0 = dut_vrise; d0 = dut_drops;
    @(negedge clk);
    bus.i_Ready = 1'b0;
    dwell(0, 7'h12, 8); dwell(1, 7'h02, 8); dwell(2, 7'h00, 8); dwell(3, 7'h18, 8);
    idle(4);
    for (int p = 0; p < ND; p++) dwell(p, 7'h40, 8);
    idle(4);
    chk("t4_valid_held", bus.o_Valid, 1);
    chk("t4_data_held", bus.o_Data, 16'h9865);
    chk("t4_drops", dut_drops - d0, 1);
    chk("t4_frames", dut_vrise - v0, 1);
    @(negedge clk);
    bus.i_Ready = 1'b1;
    idle(3);
    chk("t4_valid_after", bus.o_Valid, 0);
    chk("t4_accepted", m_acc_d, 16'h9865);

    // 5: undecodable pattern on position 1
    v0 = dut_vrise;
    dwell(0, 7'h79, 8); dwell(1, 7'h55, 8); dwell(2, 7'h30, 8); dwell(3, 7'h19, 8);
    idle(4);
`ifdef FND_READER_ERR_EN
    chk("t5_frames", dut_vrise - v0, 1);
    chk("t5_data", last_d, 16'h43E1);
    chk("t5_err", last_e, 1);
`else
    chk("t5_frames", dut_vrise - v0, 0);
    chk("t5_valid", bus.o_Valid, 0);
`endif

    // 6: reset mid-frame discards partial captures
    do_reset();
    dwell(0, 7'h40, 8); dwell(1, 7'h79, 8);
    do_reset();
    v0 = dut_vrise;
    dwell(2, 7'h24, 8); dwell(3, 7'h30, 8);
    idle(4);
    chk("t6_partial", dut_vrise - v0, 0);
    dwell(0, 7'h40, 8); dwell(1, 7'h79, 8);
    idle(4);
    chk("t6_frames", dut_vrise - v0, 1);
    chk("t6_data", last_d, 16'h3210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
